anton_neopixel_stream_tx: RTL and testbench

//  Reads the pixel frame buffer that the bus-side register block fills, and serialises it onto the NeoPixel
//  (WS2812) one-wire line. Each byte is sent MSB first; each frame ends with a latch (reset) period.

---
 rtl/anton_neopixel_stream_tx_pkg.sv | 60 ++++++
 rtl/anton_neopixel_stream_tx_if.sv | 40 ++++
 rtl/anton_neopixel_bit_timer.sv | 55 +++++
 rtl/anton_neopixel_stream_tx.sv | 175 +++++++++++++++++
 tb/tb_anton_neopixel_stream_tx.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/anton_neopixel_stream_tx_pkg.sv
// -----------------------------------------------------------------------------
// anton_neopixel_stream_tx_pkg
// Shared definitions for the NeoPixel (WS2812) stream transmitter:
//   - default timing constants (clock counts at 20 MHz)
//   - FSM state encoding
//   - clog2 / buffer-end sanitising helpers
//   - the frame-buffer index advance rule (32-bit mode skips ix[1:0]==3)
// Optional build macro used by the transmitter: ANTON_NEOPIXEL_TX_INVERT_EN
// -----------------------------------------------------------------------------
package anton_neopixel_stream_tx_pkg;

  localparam int BUFFER_END_DEFAULT   = 1023;
  localparam int T0H_CYCLES_DEFAULT   = 8;    // 0.40 us
  localparam int T1H_CYCLES_DEFAULT   = 16;   // 0.80 us
  localparam int BIT_CYCLES_DEFAULT   = 25;   // 1.25 us
  localparam int RESET_CYCLES_DEFAULT = 1000; // 50 us latch

  // Byte indices are compared at 14 bits so ix+2 never wraps past a 13-bit end.
  localparam int IX_WIDTH = 14;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_DATA     = 2'd2,
    S_LATCH    = 2'd3
  } tx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // regMax is 13 bits wide, so the buffer can never extend past index 8191.
  function automatic int sanitize_buffer_end(input int buffer_end);
    if (buffer_end < 0) begin
      return 0;
    end
    if (buffer_end > 8191) begin
      return 8191;
    end
    return buffer_end;
  endfunction

  // Next transmitted index after ix. In 32-bit mode the fourth byte of each
  // pixel word (ix[1:0]==3) is padding and is skipped.
  function automatic logic [IX_WIDTH-1:0] next_byte_ix(input logic [IX_WIDTH-1:0] ix,
                                                       input logic mode32);
    logic [IX_WIDTH-1:0] n;
    n = ix + IX_WIDTH'(1);
    if (mode32 && (n[1:0] == 2'b11)) begin
      n = ix + IX_WIDTH'(2);
    end
    return n;
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_tx_if.sv
// -----------------------------------------------------------------------------
// anton_neopixel_stream_tx_if
// Connection between the bus-side register block / frame-buffer RAM and the
// NeoPixel stream transmitter.
//   master : register block + RAM read port (drives control and pixelByte)
//   slave  : transmitter (drives pixelIxComb, streamSyncOf, state)
// Signals:
//   regMax[12:0]   last byte index when regCtrlLimit=1
//   regCtrlInit    abort/hold
//   regCtrlLimit   use regMax as frame end
//   regCtrlRun     start request
//   regCtrl32bit   4 bytes per pixel, ix[1:0]==3 skipped
//   pixelIxComb    RAM read address (data returns one clock later)
//   pixelByte      RAM read data
//   streamSyncOf   one-cycle pulse at end of latch period
//   state          1 while a frame is in progress
// -----------------------------------------------------------------------------
interface anton_neopixel_stream_tx_if #(
  parameter int BUFFER_BITS = 10
);
  logic [12:0]            regMax;
  logic                   regCtrlInit;
  logic                   regCtrlLimit;
  logic                   regCtrlRun;
  logic                   regCtrl32bit;
  logic [BUFFER_BITS-1:0] pixelIxComb;
  logic [7:0]             pixelByte;
  logic                   streamSyncOf;
  logic                   state;

  modport master (
    output regMax, regCtrlInit, regCtrlLimit, regCtrlRun, regCtrl32bit, pixelByte,
    input  pixelIxComb, streamSyncOf, state
  );

  modport slave (
    input  regMax, regCtrlInit, regCtrlLimit, regCtrlRun, regCtrl32bit, pixelByte,
    output pixelIxComb, streamSyncOf, state
  );
endinterface

// File: rtl/anton_neopixel_bit_timer.sv
// -----------------------------------------------------------------------------
// anton_neopixel_bit_timer
// Per-bit cycle counter for the NeoPixel waveform.
// Ports:
//   busClk     clock
//   syncReset  synchronous active-high reset
//   run        1 while the transmitter is in DATA (counter free-runs 0..BIT-1)
//   bit_value  the bit that will be on the line next cycle
//   level      line level for the NEXT cycle (so the caller can register it)
//   bit_done   current cycle is the last one of a bit period
// -----------------------------------------------------------------------------
module anton_neopixel_bit_timer
  import anton_neopixel_stream_tx_pkg::*;
#(
  parameter int T0H_CYCLES = T0H_CYCLES_DEFAULT,
  parameter int T1H_CYCLES = T1H_CYCLES_DEFAULT,
  parameter int BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic busClk,
  input  logic syncReset,
  input  logic run,
  input  logic bit_value,
  output logic level,
  output logic bit_done
);

  localparam int CNT_BITS = (clog2(BIT_CYCLES) < 1) ? 1 : clog2(BIT_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BIT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] T0H_CNT  = CNT_BITS'(T0H_CYCLES);
  localparam logic [CNT_BITS-1:0] T1H_CNT  = CNT_BITS'(T1H_CYCLES);

  logic [CNT_BITS-1:0] cnt_reg;
  logic [CNT_BITS-1:0] cnt_next;

  // Outside DATA the counter parks at 0, so the first DATA cycle is cycle 0.
  always_comb begin
    cnt_next = '0;
    if (run && (cnt_reg != CNT_LAST)) begin
      cnt_next = cnt_reg + CNT_BITS'(1);
    end
  end

  always_ff @(posedge busClk) begin
    if (syncReset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_done = run && (cnt_reg == CNT_LAST);
  // Look-ahead compare: evaluated against next cycle's count and bit.
  assign level    = (cnt_next < (bit_value ? T1H_CNT : T0H_CNT));

endmodule

// File: rtl/anton_neopixel_stream_tx.sv
// -----------------------------------------------------------------------------
// anton_neopixel_stream_tx
// Reads the pixel frame buffer and serialises it onto the WS2812 one-wire line,
// MSB first, back-to-back bits, followed by a latch (low) period per frame.
// Ports:
//   busClk     single clock shared with the register block
//   syncReset  synchronous active-high reset
//   bus        anton_neopixel_stream_tx_if.slave (register controls, RAM read
//              port, streamSyncOf pulse and busy state)
//   neoData    registered serial output
// Build option: ANTON_NEOPIXEL_TX_INVERT_EN inverts neoData (reset and latch
// level become 1) for use behind an inverting level shifter.
// -----------------------------------------------------------------------------
module anton_neopixel_stream_tx
  import anton_neopixel_stream_tx_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int T0H_CYCLES   = T0H_CYCLES_DEFAULT,
  parameter int T1H_CYCLES   = T1H_CYCLES_DEFAULT,
  parameter int BIT_CYCLES   = BIT_CYCLES_DEFAULT,   // > T1H_CYCLES > T0H_CYCLES > 0
  parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic                        busClk,
  input  logic                        syncReset,
  anton_neopixel_stream_tx_if.slave   bus,
  output logic                        neoData
);

  localparam int BUF_END     = sanitize_buffer_end(BUFFER_END);
  localparam int BUFFER_BITS = (clog2(BUF_END + 1) < 1) ? 1 : clog2(BUF_END + 1);
  localparam int LATCH_BITS  = (clog2(RESET_CYCLES) < 1) ? 1 : clog2(RESET_CYCLES);
  localparam logic [LATCH_BITS-1:0] LATCH_LAST = LATCH_BITS'(RESET_CYCLES - 1);
  localparam logic [IX_WIDTH-1:0]   BUF_END_IX = IX_WIDTH'(BUF_END);

`ifdef ANTON_NEOPIXEL_TX_INVERT_EN
  localparam logic IDLE_LEVEL = 1'b1;
`else
  localparam logic IDLE_LEVEL = 1'b0;
`endif

  tx_state_t state_reg, state_next;

  logic [BUFFER_BITS-1:0] byte_ix_reg, byte_ix_next;
  logic [7:0]             shift_reg, shift_next;
  logic [2:0]             bit_cnt_reg, bit_cnt_next;
  logic                   last_reg, last_next;     // byte in shift_reg is the frame's last
  logic [LATCH_BITS-1:0]  latch_cnt_reg, latch_cnt_next;
  logic                   neo_reg, neo_next;
  logic                   sync_reg, sync_next;

  logic                   level;
  logic                   bit_done;
  logic                   load_byte;
  logic                   byte_done;
  logic [IX_WIDTH-1:0]    end_ix;
  logic [IX_WIDTH-1:0]    cur_ix;
  logic [IX_WIDTH-1:0]    adv_ix;
  logic                   adv_is_last;

  anton_neopixel_bit_timer #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .busClk    (busClk),
    .syncReset (syncReset),
    .run       (state_reg == S_DATA),
    .bit_value (shift_next[7]),
    .level     (level),
    .bit_done  (bit_done)
  );

  // Frame end and index advance; limit/mode/max are only changed while idle.
  always_comb begin
    end_ix = BUF_END_IX;
    if (bus.regCtrlLimit && ({1'b0, bus.regMax} < BUF_END_IX)) begin
      end_ix = {1'b0, bus.regMax};
    end
    cur_ix      = IX_WIDTH'(byte_ix_reg);
    adv_ix      = next_byte_ix(cur_ix, bus.regCtrl32bit);
    adv_is_last = (adv_ix > end_ix);
  end

  assign byte_done = (state_reg == S_DATA) && bit_done && (bit_cnt_reg == 3'd0);
  assign load_byte = (state_reg == S_PREFETCH) || (byte_done && !last_reg);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge busClk) begin
    if (syncReset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    if (bus.regCtrlInit) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE:     if (bus.regCtrlRun) state_next = S_PREFETCH;
        S_PREFETCH: state_next = S_DATA;
        S_DATA:     if (byte_done && last_reg) state_next = S_LATCH;
        S_LATCH:    if (latch_cnt_reg == LATCH_LAST) state_next = S_IDLE;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    last_next      = last_reg;
    byte_ix_next   = byte_ix_reg;
    latch_cnt_next = '0;

    if (load_byte) begin
      // The RAM has had byte_ix_reg for at least one clock, so pixelByte is valid.
      shift_next   = bus.pixelByte;
      bit_cnt_next = 3'd7;
      last_next    = adv_is_last;
      // Hold the address on the last byte so it never leaves the buffer.
      if (!adv_is_last) begin
        byte_ix_next = adv_ix[BUFFER_BITS-1:0];
      end
    end else if ((state_reg == S_DATA) && bit_done && (bit_cnt_reg != 3'd0)) begin
      shift_next   = {shift_reg[6:0], 1'b0};
      bit_cnt_next = bit_cnt_reg - 3'd1;
    end

    if (state_next == S_IDLE) begin
      byte_ix_next = '0;
    end

    if ((state_reg == S_LATCH) && (state_next == S_LATCH)) begin
      latch_cnt_next = latch_cnt_reg + LATCH_BITS'(1);
    end
  end

  always_ff @(posedge busClk) begin
    if (syncReset) begin
      byte_ix_reg   <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      last_reg      <= 1'b0;
      latch_cnt_reg <= '0;
      neo_reg       <= IDLE_LEVEL;
      sync_reg      <= 1'b0;
    end else begin
      byte_ix_reg   <= byte_ix_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      last_reg      <= last_next;
      latch_cnt_reg <= latch_cnt_next;
      neo_reg       <= neo_next;
      sync_reg      <= sync_next;
    end
  end

  // ---------------- FSM: outputs ----------------
  // neoData and streamSyncOf are registered from next-state values so they
  // line up with the state they describe without any input-to-output path.
  always_comb begin
    neo_next         = ((state_next == S_DATA) && level) ^ IDLE_LEVEL;
    sync_next        = (state_next == S_LATCH) && (latch_cnt_next == LATCH_LAST);
    bus.pixelIxComb  = byte_ix_reg;
    bus.streamSyncOf = sync_reg;
    bus.state        = (state_reg != S_IDLE);
    neoData          = neo_reg;
  end

endmodule

// File: tb/tb_anton_neopixel_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_anton_neopixel_stream_tx
// Randomised self-checking bench for anton_neopixel_stream_tx with
// T0H=2, T1H=4, BIT=6, RESET=10, BUFFER_END=7. Includes a register-block
// model (Run cleared by streamSyncOf unless Loop) and a registered-read RAM.
// The reference derives the sent index list and the expected line waveform
// directly from the frame rules.
// -----------------------------------------------------------------------------
module tb_anton_neopixel_stream_tx;

  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int BITC = 6;
  localparam int RST_CYC = 10;
  localparam int BUF_END = 7;
  localparam int SPB = 8 * BITC;   // samples per byte

`ifdef ANTON_NEOPIXEL_TX_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        syncReset;
  logic        neoData;
  logic [12:0] cfg_max;
  logic        cfg_init, cfg_limit, cfg_32;
  logic        run_set, run_q, loop;
  logic [7:0]  pixel_byte_q;
  logic [7:0]  ram [0:7];

  anton_neopixel_stream_tx_if #(.BUFFER_BITS(3)) bus_if ();

  anton_neopixel_stream_tx #(
    .BUFFER_END   (BUF_END),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .BIT_CYCLES   (BITC),
    .RESET_CYCLES (RST_CYC)
  ) dut (
    .busClk    (clk),
    .syncReset (syncReset),
    .bus       (bus_if),
    .neoData   (neoData)
  );

  assign bus_if.regMax       = cfg_max;
  assign bus_if.regCtrlInit  = cfg_init;
  assign bus_if.regCtrlLimit = cfg_limit;
  assign bus_if.regCtrl32bit = cfg_32;
  assign bus_if.regCtrlRun   = run_q;
  assign bus_if.pixelByte    = pixel_byte_q;

  // Register block Run bit and registered-read RAM.
  always @(posedge clk) begin
    if (syncReset) run_q <= 1'b0;
    else if (run_set) run_q <= 1'b1;
    else if (bus_if.streamSyncOf && !loop) run_q <= 1'b0;
    pixel_byte_q <= ram[bus_if.pixelIxComb];
  end

  int tests_run = 0;
  int tests_failed = 0;

  bit obs_neo[$];
  int obs_ix[$];
  int ref_ix[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // Indices sent for a frame: start at 0, step by one (skip ix%4==3 in 32-bit
  // mode), stop once the next index would pass the end index.
  task automatic build_ref(input bit lim, input int mx, input bit m32);
    int end_ix, ix, nxt;
    end_ix = lim ? ((mx < BUF_END) ? mx : BUF_END) : BUF_END;
    ref_ix.delete();
    ix = 0;
    while (1) begin
      ref_ix.push_back(ix);
      nxt = ix + 1;
      if (m32 && (nxt % 4 == 3)) nxt = ix + 2;
      if (nxt > end_ix) break;
      ix = nxt;
    end
  endtask

  // Expected 48-sample waveform of one byte, first sample at bit 47.
  function automatic logic [63:0] wave(input logic [7:0] b);
    logic [63:0] w;
    int pos;
    w = '0;
    pos = SPB - 1;
    for (int i = 7; i >= 0; i--) begin
      for (int c = 0; c < BITC; c++) begin
        w[pos] = (c < (b[i] ? T1H : T0H));
        pos--;
      end
    end
    return w;
  endfunction

  function automatic logic sample(input int i);
    if (i < obs_neo.size()) return obs_neo[i];
    return 1'bx;
  endfunction

  task automatic fill_ram();
    for (int i = 0; i < 8; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  // Sample once per clock (negedge) until the streamSyncOf pulse or budget.
  task automatic capture(input int lead, input bit drop_loop, output int sync_idx);
    int budget;
    budget = lead + ref_ix.size() * SPB + RST_CYC + 20;
    obs_neo.delete();
    obs_ix.delete();
    sync_idx = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      run_set = 1'b0;
      obs_neo.push_back(neoData);
      obs_ix.push_back(int'(bus_if.pixelIxComb));
      if (i == 0 && drop_loop) loop = 1'b0;
      if (bus_if.streamSyncOf) begin
        sync_idx = i;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input int lead, input int sync_idx);
    logic [63:0] got, expv, got_ix, exp_ix;
    int n, base, prev, cnt;
    n = ref_ix.size();
    got = '0;
    for (int i = 0; i < lead; i++) got[i] = sample(i);
    check({name, "_lead"}, got, INV ? ((64'd1 << lead) - 64'd1) : 64'd0);
    for (int k = 0; k < n; k++) begin
      got = '0;
      base = lead + k * SPB;
      for (int j = 0; j < SPB; j++) got[SPB-1-j] = sample(base + j);
      expv = wave(ram[ref_ix[k]]);
      if (INV) expv = expv ^ ((64'd1 << SPB) - 64'd1);
      check($sformatf("%s_byte%0d_ix%0d", name, k, ref_ix[k]), got, expv);
    end
    base = lead + n * SPB;
    got = '0;
    for (int j = 0; j < RST_CYC; j++) got[j] = sample(base + j);
    check({name, "_latch"}, got, INV ? ((64'd1 << RST_CYC) - 64'd1) : 64'd0);
    check({name, "_sync_pos"}, 64'(sync_idx), 64'(base + RST_CYC - 1));
    prev = -1; cnt = 0; got_ix = '0;
    for (int i = 0; i < base && i < obs_ix.size(); i++) begin
      if (obs_ix[i] != prev) begin
        if (cnt < 16) got_ix[cnt*4 +: 4] = 4'(obs_ix[i]);
        cnt++;
        prev = obs_ix[i];
      end
    end
    exp_ix = '0;
    for (int k = 0; k < n; k++) exp_ix[k*4 +: 4] = 4'(ref_ix[k]);
    check({name, "_ix_seq"}, got_ix, exp_ix);
    check({name, "_ix_cnt"}, 64'(cnt), 64'(n));
  endtask

  task automatic idle_check(input string name);
    repeat (3) @(negedge clk);
    check({name, "_state_idle"}, 64'(bus_if.state), 64'd0);
    check({name, "_neo_idle"}, 64'(neoData), 64'(INV));
  endtask

  task automatic run_frame(input string name, input bit lim, input logic [12:0] mx,
                           input bit m32, input bit rnd);
    int sidx;
    @(negedge clk);
    cfg_limit = lim; cfg_max = mx; cfg_32 = m32;
    if (rnd) fill_ram();
    build_ref(lim, int'(mx), m32);
    run_set = 1'b1;
    capture(2, 1'b0, sidx);
    check_frame(name, 2, sidx);
    idle_check(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sidx, highs, busy, syncs;
    syncReset = 1'b1; cfg_max = '0; cfg_init = 1'b0; cfg_limit = 1'b0; cfg_32 = 1'b0;
    run_set = 1'b0; loop = 1'b0;
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_neo", 64'(neoData), 64'(INV));
    check("reset_sync", 64'(bus_if.streamSyncOf), 64'd0);
    check("reset_state", 64'(bus_if.state), 64'd0);
    check("reset_ix", 64'(bus_if.pixelIxComb), 64'd0);
    syncReset = 1'b0;

    // 1: single byte A5h
    ram[0] = 8'hA5;
    run_frame("t1_one_byte", 1'b1, 13'd0, 1'b0, 1'b0);

    // 2: full buffer in 32-bit mode
    run_frame("t2_32bit", 1'b0, 13'd0, 1'b1, 1'b1);

    // 3: looping, two frames back to back
    @(negedge clk);
    cfg_limit = 1'b1; cfg_max = 13'd2; cfg_32 = 1'b0; loop = 1'b1;
    fill_ram();
    build_ref(1'b1, 2, 1'b0);
    run_set = 1'b1;
    capture(2, 1'b0, sidx);
    check_frame("t3_loop_f1", 2, sidx);
    capture(2, 1'b1, sidx);
    check_frame("t3_loop_f2", 2, sidx);
    idle_check("t3_loop_end");

    // 4: Init mid byte 1, Run held off by Init, resume after release
    @(negedge clk);
    cfg_limit = 1'b0; cfg_32 = 1'b0;
    fill_ram();
    run_set = 1'b1;
    repeat (56) begin @(negedge clk); run_set = 1'b0; end
    cfg_init = 1'b1;
    @(negedge clk);
    check("t4_init_neo", 64'(neoData), 64'(INV));
    check("t4_init_state", 64'(bus_if.state), 64'd0);
    check("t4_init_sync", 64'(bus_if.streamSyncOf), 64'd0);
    run_set = 1'b1;
    highs = 0; busy = 0; syncs = 0;
    repeat (25) begin
      @(negedge clk);
      run_set = 1'b0;
      if (neoData !== INV) highs++;
      if (bus_if.state !== 1'b0) busy++;
      if (bus_if.streamSyncOf !== 1'b0) syncs++;
    end
    check("t4_hold_highs", 64'(highs), 64'd0);
    check("t4_hold_busy", 64'(busy), 64'd0);
    check("t4_hold_syncs", 64'(syncs), 64'd0);
    build_ref(1'b0, 0, 1'b0);
    cfg_init = 1'b0;
    capture(1, 1'b0, sidx);
    check_frame("t4_resume", 1, sidx);
    idle_check("t4_resume");

    // 5: syncReset during LATCH, then 6: clamped regMax restarts from 0
    @(negedge clk);
    cfg_limit = 1'b1; cfg_max = 13'd0;
    run_set = 1'b1;
    repeat (54) begin @(negedge clk); run_set = 1'b0; end
    check("t5_in_latch_state", 64'(bus_if.state), 64'd1);
    syncReset = 1'b1;
    @(negedge clk);
    check("t5_rst_neo", 64'(neoData), 64'(INV));
    check("t5_rst_sync", 64'(bus_if.streamSyncOf), 64'd0);
    check("t5_rst_state", 64'(bus_if.state), 64'd0);
    check("t5_rst_ix", 64'(bus_if.pixelIxComb), 64'd0);
    syncReset = 1'b0;
    run_frame("t6_clamp", 1'b1, 13'h1FFF, 1'b0, 1'b1);

    // randomised configurations
    for (int r = 0; r < 5; r++) begin
      run_frame($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
